// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: FSM state encoding and jump-condition codes.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEMWAIT,
    ST_DONE
  } state_t;

  localparam logic [1:0] COND_EQ = 2'b00;
  localparam logic [1:0] COND_NE = 2'b01;
  localparam logic [1:0] COND_LT = 2'b10;
  localparam logic [1:0] COND_GE = 2'b11;

  function automatic logic cond_met(input logic [1:0] sel, input logic z, input logic n);
    case (sel)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_LT: return n;
      default: return !n;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch resolution: decides whether the current jump is taken and picks the next PC.
module branch_resolve #(
  parameter int PC_W = 10
) (
  input  logic            i_jtype,
  input  logic            i_uncd_jmp,
  input  logic [1:0]      i_cond_sel,
  input  logic            i_z,
  input  logic            i_n,
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_target,
  output logic            o_taken,
  output logic [PC_W-1:0] o_next_pc
);
  import seq_pkg::*;

  assign o_taken   = i_jtype & (i_uncd_jmp | cond_met(i_cond_sel, i_z, i_n));
  assign o_next_pc = o_taken ? i_target : i_pc + PC_W'(1);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: PC, condition flags and per-instruction FSM.
// Optional retired-instruction counter on o_instr_cnt when SEQ_PERF_CNT_EN is defined.
module instr_sequencer #(
  parameter int              PC_W      = 10,
  parameter logic [PC_W-1:0] PROG_LAST = {PC_W{1'b1}}
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_halt,
  input  logic            i_jtype,
  input  logic            i_uncd_jmp,
  input  logic [1:0]      i_cond_sel,
  input  logic            i_rd_mem,
  input  logic            i_flag_wr,
  input  logic            i_alu_zero,
  input  logic            i_alu_neg,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_prog_ctr,
  output logic            o_exec_en,
  output logic            o_load_wb,
  output logic            o_done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]     o_instr_cnt
`endif
);
  import seq_pkg::*;

  state_t          r_state;
  state_t          w_state_next;
  logic [PC_W-1:0] r_pc;
  logic            r_z;
  logic            r_n;
  logic            r_end_after_load;
  logic            w_taken;
  logic [PC_W-1:0] w_next_pc;
  logic            w_fall_off;
  logic            w_launch;

  branch_resolve #(.PC_W(PC_W)) u_branch (
    .i_jtype   (i_jtype),
    .i_uncd_jmp(i_uncd_jmp),
    .i_cond_sel(i_cond_sel),
    .i_z       (r_z),
    .i_n       (r_n),
    .i_pc      (r_pc),
    .i_target  (i_target),
    .o_taken   (w_taken),
    .o_next_pc (w_next_pc)
  );

  // Falling through the last address ends the run instead of wrapping.
  assign w_fall_off = !w_taken && (r_pc == PROG_LAST);
  assign w_launch   = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_start) w_state_next = ST_FETCH;
      ST_FETCH:   w_state_next = ST_EXEC;
      ST_EXEC: begin
        if (i_halt)          w_state_next = ST_DONE;
        else if (i_rd_mem)   w_state_next = ST_MEMWAIT;
        else if (w_fall_off) w_state_next = ST_DONE;
        else                 w_state_next = ST_FETCH;
      end
      ST_MEMWAIT: w_state_next = r_end_after_load ? ST_DONE : ST_FETCH;
      ST_DONE:    if (i_start) w_state_next = ST_FETCH;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || w_launch) begin
      r_pc             <= '0;
      r_z              <= 1'b0;
      r_n              <= 1'b0;
      r_end_after_load <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      if (!i_halt && !w_fall_off) r_pc <= w_next_pc;
      if (i_flag_wr) begin
        r_z <= i_alu_zero;
        r_n <= i_alu_neg;
      end
      // Remembered so a load at the last address ends the run after its writeback.
      r_end_after_load <= w_fall_off && !i_halt;
    end
  end

  assign o_prog_ctr = r_pc;
  assign o_exec_en  = (r_state == ST_EXEC);
  assign o_load_wb  = (r_state == ST_MEMWAIT);
  assign o_done     = (r_state == ST_DONE);

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_instr_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || w_launch)                              r_instr_cnt <= '0;
    else if ((r_state == ST_EXEC) && (r_instr_cnt != '1)) r_instr_cnt <= r_instr_cnt + 32'd1;
  end

  assign o_instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed tables plus random programs against an
// instruction-level reference interpreter.
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int              PC_W      = 10;
  localparam int              DEPTH     = 1 << PC_W;
  localparam logic [PC_W-1:0] PROG_LAST = 10'd15;

  typedef struct packed {
    logic            halt;
    logic            jtype;
    logic            uncd;
    logic [1:0]      cond;
    logic            rdmem;
    logic            flagwr;
    logic            zero;
    logic            neg;
    logic [PC_W-1:0] target;
  } ins_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            ex;
    logic            lw;
    logic            dn;
  } obs_t;

  typedef struct {
    string           name;
    logic            z0;
    logic            n0;
    logic            jtype;
    logic            uncd;
    logic [1:0]      cond;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] exp_pc;
  } br_vec_t;

  logic            clk;
  logic            reset;
  logic            start;
  logic            halt;
  logic            jtype;
  logic            uncd_jmp;
  logic [1:0]      cond_sel;
  logic            rd_mem;
  logic            flag_wr;
  logic            alu_zero;
  logic            alu_neg;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] prog_ctr;
  logic            exec_en;
  logic            load_wb;
  logic            done;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]     instr_cnt;
`endif

  ins_t    prog [DEPTH];
  obs_t    exp_q[$];
  bit      exp_ended;
  int      exp_cnt;
  int      n_checks = 0;
  int      n_errors = 0;
  br_vec_t vecs[10];

  instr_sequencer #(.PC_W(PC_W), .PROG_LAST(PROG_LAST)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_start   (start),
    .i_halt    (halt),
    .i_jtype   (jtype),
    .i_uncd_jmp(uncd_jmp),
    .i_cond_sel(cond_sel),
    .i_rd_mem  (rd_mem),
    .i_flag_wr (flag_wr),
    .i_alu_zero(alu_zero),
    .i_alu_neg (alu_neg),
    .i_target  (target),
    .o_prog_ctr(prog_ctr),
    .o_exec_en (exec_en),
    .o_load_wb (load_wb),
    .o_done    (done)
`ifdef SEQ_PERF_CNT_EN
    ,
    .o_instr_cnt(instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ins_t op_alu();
    return '0;
  endfunction

  function automatic ins_t op_halt();
    ins_t c = '0;
    c.halt = 1'b1;
    return c;
  endfunction

  function automatic ins_t op_load();
    ins_t c = '0;
    c.rdmem = 1'b1;
    return c;
  endfunction

  function automatic ins_t op_cmp(input logic z, input logic n);
    ins_t c = '0;
    c.flagwr = 1'b1;
    c.zero   = z;
    c.neg    = n;
    return c;
  endfunction

  function automatic ins_t op_jmp(input logic u, input logic [1:0] cs, input logic [PC_W-1:0] t);
    ins_t c = '0;
    c.jtype  = 1'b1;
    c.uncd   = u;
    c.cond   = cs;
    c.target = t;
    return c;
  endfunction

  function automatic obs_t mk_obs(input logic [PC_W-1:0] pc, input logic ex, input logic lw,
                                  input logic dn);
    obs_t o;
    o.pc = pc;
    o.ex = ex;
    o.lw = lw;
    o.dn = dn;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk_obs(prog_ctr, exec_en, load_wb, done);
  endfunction

  function automatic br_vec_t mkv(input string nm, input logic z0, input logic n0,
                                  input logic jt, input logic u, input logic [1:0] cs,
                                  input logic [PC_W-1:0] t, input logic [PC_W-1:0] e);
    br_vec_t v;
    v.name = nm; v.z0 = z0; v.n0 = n0; v.jtype = jt; v.uncd = u;
    v.cond = cs; v.target = t; v.exp_pc = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock, then present the decoder fields of the instruction at the current PC.
  task automatic step();
    ins_t c;
    @(posedge clk);
    #1;
    c        = prog[prog_ctr];
    halt     = c.halt;
    jtype    = c.jtype;
    uncd_jmp = c.uncd;
    cond_sel = c.cond;
    rd_mem   = c.rdmem;
    flag_wr  = c.flagwr;
    alu_zero = c.zero;
    alu_neg  = c.neg;
    target   = c.target;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic clear_prog();
    for (int a = 0; a < DEPTH; a++) prog[a] = op_alu();
  endtask

  // Instruction-level interpreter: each instruction costs FETCH+EXEC, loads add a writeback cycle.
  task automatic model();
    logic [PC_W-1:0] pc;
    logic            z, n, cm, tk, fo;
    ins_t            c;
    exp_q.delete();
    pc = '0; z = 1'b0; n = 1'b0;
    exp_cnt = 0;
    exp_ended = 1'b0;
    for (int k = 0; k < 200 && !exp_ended; k++) begin
      c = prog[pc];
      exp_q.push_back(mk_obs(pc, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk_obs(pc, 1'b1, 1'b0, 1'b0));
      exp_cnt++;
      if (c.halt) begin
        exp_ended = 1'b1;
      end else begin
        case (c.cond)
          COND_EQ: cm = z;
          COND_NE: cm = !z;
          COND_LT: cm = n;
          default: cm = !n;
        endcase
        tk = c.jtype && (c.uncd || cm);
        fo = !tk && (pc == PROG_LAST);
        if (c.flagwr) begin
          z = c.zero;
          n = c.neg;
        end
        if (!fo) pc = tk ? c.target : pc + 10'd1;
        if (c.rdmem) exp_q.push_back(mk_obs(pc, 1'b0, 1'b1, 1'b0));
        if (fo) exp_ended = 1'b1;
      end
    end
    if (exp_ended) repeat (3) exp_q.push_back(mk_obs(pc, 1'b0, 1'b0, 1'b1));
  endtask

  // Launch from IDLE/DONE and compare every cycle; optionally toggles Start while running.
  task automatic run_prog(input string tag, input bit rand_start);
    model();
    start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      step();
      check(tag, 64'(observe()), 64'(exp_q[i]));
`ifdef SEQ_PERF_CNT_EN
      if (i == 0) check({tag, "_cnt_clr"}, 64'(instr_cnt), 64'd0);
`endif
      start = exp_q[i].dn ? 1'b0 : (rand_start ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    start = 1'b0;
    if (exp_ended) begin
`ifdef SEQ_PERF_CNT_EN
      check({tag, "_cnt_done"}, 64'(instr_cnt), 64'(exp_cnt));
`endif
    end else begin
      do_reset();
    end
  endtask

  task automatic gen_random();
    clear_prog();
    for (int a = 0; a < 16; a++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 40)      prog[a] = op_alu();
      else if (r < 55) prog[a] = op_cmp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (r < 75) prog[a] = op_jmp(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                                        PC_W'($urandom_range(0, 15)));
      else if (r < 92) prog[a] = op_load();
      else             prog[a] = op_halt();
    end
  endtask

  initial begin
    vecs[0] = mkv("eq_taken",    1'b1, 1'b0, 1'b1, 1'b0, COND_EQ, 10'd9,  10'd9);
    vecs[1] = mkv("eq_not",      1'b0, 1'b0, 1'b1, 1'b0, COND_EQ, 10'd9,  10'd2);
    vecs[2] = mkv("ne_taken",    1'b0, 1'b1, 1'b1, 1'b0, COND_NE, 10'd9,  10'd9);
    vecs[3] = mkv("ne_not",      1'b1, 1'b0, 1'b1, 1'b0, COND_NE, 10'd9,  10'd2);
    vecs[4] = mkv("lt_taken",    1'b0, 1'b1, 1'b1, 1'b0, COND_LT, 10'd12, 10'd12);
    vecs[5] = mkv("lt_not",      1'b1, 1'b0, 1'b1, 1'b0, COND_LT, 10'd12, 10'd2);
    vecs[6] = mkv("ge_taken_0",  1'b0, 1'b0, 1'b1, 1'b0, COND_GE, 10'd0,  10'd0);
    vecs[7] = mkv("ge_not",      1'b0, 1'b1, 1'b1, 1'b0, COND_GE, 10'd0,  10'd2);
    vecs[8] = mkv("uncd_last",   1'b0, 1'b0, 1'b1, 1'b1, COND_EQ, 10'd15, 10'd15);
    vecs[9] = mkv("not_jump",    1'b1, 1'b0, 1'b0, 1'b1, COND_EQ, 10'd7,  10'd2);

    reset = 1'b1; start = 1'b0; halt = 1'b0; jtype = 1'b0; uncd_jmp = 1'b0;
    cond_sel = 2'b00; rd_mem = 1'b0; flag_wr = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;
    target = '0;
    clear_prog();
    step();
    step();
    check("reset_state", 64'(observe()), 64'(mk_obs(10'd0, 1'b0, 1'b0, 1'b0)));
    reset = 1'b0;
    repeat (3) step();
    check("idle_hold", 64'(observe()), 64'(mk_obs(10'd0, 1'b0, 1'b0, 1'b0)));

    // Reset lands while a load is in EXEC: no writeback may follow.
    prog[0] = op_load();
    start = 1'b1;
    step();
    start = 1'b0;
    check("load_fetch", 64'(observe()), 64'(mk_obs(10'd0, 1'b0, 1'b0, 1'b0)));
    step();
    check("load_exec", 64'(observe()), 64'(mk_obs(10'd0, 1'b1, 1'b0, 1'b0)));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_load", 64'(observe()), 64'(mk_obs(10'd0, 1'b0, 1'b0, 1'b0)));
    step();
    check("no_lwb_after_rst", 64'(observe()), 64'(mk_obs(10'd0, 1'b0, 1'b0, 1'b0)));

    // Three ALU ops then halt: Done on the 9th cycle after launch, PC frozen at 3.
    clear_prog();
    prog[3] = op_halt();
    run_prog("alu_halt", 1'b0);
    check("halt_pc_frozen", 64'(prog_ctr), 64'd3);

    for (int v = 0; v < 10; v++) begin
      do_reset();
      clear_prog();
      prog[0] = op_cmp(vecs[v].z0, vecs[v].n0);
      prog[1] = op_jmp(vecs[v].uncd, vecs[v].cond, vecs[v].target);
      prog[1].jtype = vecs[v].jtype;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      check(vecs[v].name, {prog_ctr, exec_en}, {vecs[v].exp_pc, 1'b0});
    end
    do_reset();

    clear_prog();
    prog[4] = op_cmp(1'b1, 1'b0);
    prog[5] = op_jmp(1'b0, COND_EQ, 10'd20);
    prog[6] = op_halt();
    prog[20] = op_halt();
    run_prog("cmp_eq_taken", 1'b0);
    check("eq_taken_pc20", 64'(prog_ctr), 64'd20);
    prog[4] = op_cmp(1'b0, 1'b0);
    run_prog("cmp_eq_not", 1'b0);
    check("eq_not_pc6", 64'(prog_ctr), 64'd6);

    clear_prog();
    prog[7] = op_load();
    prog[8] = op_halt();
    run_prog("load_pc7", 1'b0);

    clear_prog();
    prog[15] = op_load();
    run_prog("load_at_last", 1'b0);
    check("load_last_pc", 64'(prog_ctr), 64'd15);

    clear_prog();
    run_prog("fall_off_last", 1'b1);
    check("no_wrap_pc", {prog_ctr, done}, {10'd15, 1'b1});

    // Unconditional jump at the last address loops back; second pass takes the EQ exit.
    clear_prog();
    prog[0]  = op_jmp(1'b0, COND_EQ, 10'd5);
    prog[4]  = op_jmp(1'b1, COND_EQ, 10'd13);
    prog[5]  = op_halt();
    prog[13] = op_cmp(1'b1, 1'b0);
    prog[15] = op_jmp(1'b1, COND_EQ, 10'd0);
    run_prog("wrap_jump", 1'b1);
    run_prog("restart_flags_clr", 1'b0);

    clear_prog();
    prog[0] = op_jmp(1'b1, COND_EQ, 10'd9);
    prog[0].rdmem = 1'b1;
    prog[9] = op_jmp(1'b1, COND_EQ, 10'd3);
    prog[9].halt = 1'b1;
    run_prog("jmp_load_halt", 1'b0);

    clear_prog();
    prog[1] = op_cmp(1'b0, 1'b1);
    prog[2] = op_load();
    prog[4] = op_halt();
    run_prog("five_instr", 1'b0);
`ifdef SEQ_PERF_CNT_EN
    check("cnt_five", 64'(instr_cnt), 64'd5);
    step();
    check("cnt_held", 64'(instr_cnt), 64'd5);
`endif
    run_prog("five_instr_again", 1'b0);

    for (int r = 0; r < 30; r++) begin
      gen_random();
      run_prog("random", 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
